// File: rtl/div_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : div_req_scheduler
// Function : Round-robin sharing of one sequential divider core among N_REQ
//            requesters, with divide-by-zero bypass and a completion watchdog.
// Revision : 1.0
// ============================================================================
module div_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_dividend,
    input  logic [N_REQ*WIDTH-1:0]     req_divisor,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       core_start,
    output logic [WIDTH-1:0]           core_dividend,
    output logic [WIDTH-1:0]           core_divisor,
    output logic                       core_clr,
    input  logic                       core_done,
    input  logic [WIDTH-1:0]           core_quotient,
    input  logic [WIDTH-1:0]           core_remainder,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_quotient,
    output logic [WIDTH-1:0]           rsp_remainder,
    output logic                       rsp_dz,
    output logic                       rsp_err
);

    localparam int c_idw = $clog2(N_REQ);
    localparam int c_cw  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_idw-1:0]    rr_ptr_q, rr_ptr_d;
    logic [c_cw-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic [c_idw-1:0]    id_q, id_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic                dz_q, dz_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic                clr_q, clr_d;

    logic [WIDTH-1:0]    w_dvd [N_REQ];
    logic [WIDTH-1:0]    w_dvs [N_REQ];
    logic                w_grant_found;
    logic [c_idw-1:0]    w_grant_idx;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_dvd[k] = req_dividend[k*WIDTH +: WIDTH];
        assign w_dvs[k] = req_divisor[k*WIDTH +: WIDTH];
    end

    // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int               cand_int;
            logic [c_idw-1:0] cand;
            cand_int = int'(rr_ptr_q) + i;
            if (cand_int >= N_REQ) cand_int = cand_int - N_REQ;
            cand = c_idw'(cand_int);
            if (!w_grant_found && req_valid[cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        id_d      = id_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        err_d     = err_q;
        start_d   = 1'b0;
        clr_d     = 1'b0;
        req_ready = '0;

        case (state_q)
            S_IDLE: begin
                if (w_grant_found && !i_rst) begin
                    req_ready = N_REQ'(1) << w_grant_idx;
                    opa_d     = w_dvd[w_grant_idx];
                    opb_d     = w_dvs[w_grant_idx];
                    id_d      = w_grant_idx;
                    err_d     = 1'b0;
                    if (w_dvs[w_grant_idx] == '0) begin
                        dz_d    = 1'b1;
                        quo_d   = '1;
                        rem_d   = w_dvd[w_grant_idx];
                        state_d = S_RESP;
                    end else begin
                        dz_d    = 1'b0;
                        quo_d   = '0;
                        rem_d   = '0;
                        start_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != c_cw'(TIMEOUT)) cnt_d = c_cw'(cnt_q + 1'b1);
                // Completion takes priority over a coincident watchdog expiry.
                if (core_done) begin
                    quo_d   = core_quotient;
                    rem_d   = core_remainder;
                    state_d = S_RESP;
                end else if (cnt_q == c_cw'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    quo_d   = '0;
                    rem_d   = '0;
                    clr_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == c_idw'(N_REQ - 1)) ? '0 : c_idw'(id_q + 1'b1);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            id_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            id_q     <= id_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
            err_q    <= err_d;
            start_q  <= start_d;
            clr_q    <= clr_d;
        end
    end

    assign core_start    = start_q;
    assign core_clr      = clr_q;
    assign core_dividend = opa_q;
    assign core_divisor  = opb_q;
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_dz        = dz_q;
    assign rsp_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_req_scheduler
// Function : Directed self-checking bench for div_req_scheduler.
// Revision : 1.0
// ============================================================================
module tb_div_req_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 32;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_dividend = '0;
    logic [N*W-1:0]   req_divisor = '0;
    logic [N-1:0]     req_ready;
    logic             core_start;
    logic [W-1:0]     core_dividend;
    logic [W-1:0]     core_divisor;
    logic             core_clr;
    logic             core_done = 1'b0;
    logic [W-1:0]     core_quotient = '0;
    logic [W-1:0]     core_remainder = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_quotient;
    logic [W-1:0]     rsp_remainder;
    logic             rsp_dz;
    logic             rsp_err;

    int total = 0;
    int bad   = 0;

    div_req_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .req_valid      (req_valid),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .req_ready      (req_ready),
        .core_start     (core_start),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_clr       (core_clr),
        .core_done      (core_done),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_quotient   (rsp_quotient),
        .rsp_remainder  (rsp_remainder),
        .rsp_dz         (rsp_dz),
        .rsp_err        (rsp_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[k*W +: W] = a;
        req_divisor[k*W +: W]  = b;
    endtask

    task automatic check_rsp(input string tag, input int id, input int q, input int r,
                             input int dz, input int err);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"},    32'(rsp_id), 32'(id));
        check({tag, "_q"},     32'(rsp_quotient), 32'(q));
        check({tag, "_r"},     32'(rsp_remainder), 32'(r));
        check({tag, "_dz"},    32'(rsp_dz), 32'(dz));
        check({tag, "_err"},   32'(rsp_err), 32'(err));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"},  32'(req_ready), 32'd0);
        check({tag, "_start"},  32'(core_start), 32'd0);
        check({tag, "_clr"},    32'(core_clr), 32'd0);
        check({tag, "_cdvd"},   32'(core_dividend), 32'd0);
        check({tag, "_cdvs"},   32'(core_divisor), 32'd0);
        check({tag, "_valid"},  32'(rsp_valid), 32'd0);
        check({tag, "_id"},     32'(rsp_id), 32'd0);
        check({tag, "_q"},      32'(rsp_quotient), 32'd0);
        check({tag, "_r"},      32'(rsp_remainder), 32'd0);
        check({tag, "_dz"},     32'(rsp_dz), 32'd0);
        check({tag, "_err"},    32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic early;
        logic stable;

        // Reset state
        repeat (3) tick();
        check_cleared("rst");
        i_rst = 1'b0;

        // Single request 100/7 from requester 0, core done 3 cycles after start
        set_op(0, 8'd100, 8'd7);
        req_valid = 4'b0001;
        #1 check("t1_grant", 32'(req_ready), 32'h1);
        tick();
        check("t1_ready_off", 32'(req_ready), 32'h0);
        check("t1_start", 32'(core_start), 32'd1);
        check("t1_cdvd", 32'(core_dividend), 32'd100);
        check("t1_cdvs", 32'(core_divisor), 32'd7);
        req_valid = '0;
        tick();
        check("t1_start_once", 32'(core_start), 32'd0);
        tick();
        tick();
        check("t1_early", 32'(rsp_valid), 32'd0);
        core_done = 1'b1; core_quotient = 8'd14; core_remainder = 8'd2;
        tick();
        core_done = 1'b0;
        check_rsp("t1", 0, 14, 2, 0, 0);
        rsp_ready = 1'b1;
        tick();
        check("t1_done", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Round robin, all requesters pending, rsp_ready tied high
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < N; k++) set_op(k, 8'd5, 8'd2);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1 check("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
            tick();
            check("rr_start", 32'(core_start), 32'd1);
            tick();
            check("rr_start_once", 32'(core_start), 32'd0);
            check("rr_ready_wait", 32'(req_ready), 32'd0);
            core_done = 1'b1; core_quotient = 8'd2; core_remainder = 8'd1;
            tick();
            core_done = 1'b0;
            check("rr_start_resp", 32'(core_start), 32'd0);
            check_rsp("rr", n % 4, 2, 1, 0, 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;

        // Divide by zero on requester 2 (rr_ptr is 1 here)
        set_op(2, 8'h5A, 8'h00);
        req_valid = 4'b0100;
        #1 check("dz_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("dz_nostart", 32'(core_start), 32'd0);
        check_rsp("dz", 2, 8'hFF, 8'h5A, 1, 0);
        rsp_ready = 1'b1;
        tick();
        check("dz_done", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Watchdog timeout on requester 3
        set_op(3, 8'd50, 8'd5);
        req_valid = 4'b1000;
        #1 check("to_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        check("to_start", 32'(core_start), 32'd1);
        tick();
        early = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (rsp_valid || core_clr) early = 1'b1;
            tick();
        end
        check("to_early", 32'(early), 32'd0);
        check("to_clr", 32'(core_clr), 32'd1);
        check_rsp("to", 3, 0, 0, 0, 1);
        tick();
        check("to_clr_once", 32'(core_clr), 32'd0);
        check("to_hold", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Normal request after timeout, then hold the response for 10 cycles
        set_op(1, 8'd9, 8'd4);
        req_valid = 4'b0010;
        #1 check("t5_grant", 32'(req_ready), 32'h2);
        tick();
        set_op(0, 8'd11, 8'd3);
        set_op(3, 8'd200, 8'd3);
        req_valid = 4'b1011;
        check("t5_start", 32'(core_start), 32'd1);
        tick();
        core_done = 1'b1; core_quotient = 8'd2; core_remainder = 8'd1;
        tick();
        core_done = 1'b0;
        check_rsp("t5", 1, 2, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            stable = rsp_valid && rsp_id == 2'd1 && rsp_quotient == 8'd2 &&
                     rsp_remainder == 8'd1 && !rsp_err && !rsp_dz && req_ready == '0 &&
                     core_dividend == 8'd9 && core_divisor == 8'd4;
            check("t5_stable", 32'(stable), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1 check("t5_next_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        check("t5_cdvd", 32'(core_dividend), 32'd200);

        // Reset during WAIT
        tick();
        i_rst = 1'b1;
        tick();
        check_cleared("wrst");
        i_rst = 1'b0;
        core_done = 1'b1; core_quotient = 8'd77; core_remainder = 8'd66;
        tick();
        core_done = 1'b0;
        check("wrst_ignore_done", 32'(rsp_valid), 32'd0);
        check("wrst_nostart", 32'(core_start), 32'd0);
        req_valid = 4'b1010;
        #1 check("wrst_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        core_done = 1'b1; core_quotient = 8'd2; core_remainder = 8'd1;
        tick();
        core_done = 1'b0;
        check_rsp("wrst", 1, 2, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
